mem_lsu: RTL and testbench

//  MEM-stage load/store unit. Consumes the execute stage's memory op (aluop, mem_addr, mem_data) and runs a

---
 rtl/mem_lsu.sv | 174 +++++++++++++++++
 tb/tb_mem_lsu.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: runs one req/ack SRAM transaction per memory op,
// stalls the pipeline until it retires, and lanes/extends store/load data.
module mem_lsu #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] BASE_MASK = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [4:0]  waddr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [4:0]  waddr_o,
  output logic        we_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic [3:0]  bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [7:0] OpLb  = 8'b1110_0000;
  localparam logic [7:0] OpLh  = 8'b1110_0001;
  localparam logic [7:0] OpLw  = 8'b1110_0011;
  localparam logic [7:0] OpLbu = 8'b1110_0100;
  localparam logic [7:0] OpLhu = 8'b1110_0101;
  localparam logic [7:0] OpSb  = 8'b1110_1000;
  localparam logic [7:0] OpSh  = 8'b1110_1001;
  localparam logic [7:0] OpSw  = 8'b1110_1011;

  // Last REQ cycle index before abort; counter starts at 0 on REQ entry.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        abort_q, abort_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  be_q, be_d;

  logic        is_load, is_store, aligned;
  logic [1:0]  a;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data;

  assign a = mem_addr_i[1:0];

  // Decode op class, alignment, store lanes and load extraction.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    aligned  = 1'b1;
    st_be    = 4'b1111;
    st_data  = mem_data_i;
    byte_sel = rdata_q[{a, 3'b000} +: 8];
    half_sel = a[1] ? rdata_q[31:16] : rdata_q[15:0];
    ld_data  = rdata_q;
    case (aluop_i)
      OpLb:  begin is_load = 1'b1; ld_data = {{24{byte_sel[7]}}, byte_sel}; end
      OpLbu: begin is_load = 1'b1; ld_data = {24'b0, byte_sel}; end
      OpLh:  begin is_load = 1'b1; aligned = ~a[0]; ld_data = {{16{half_sel[15]}}, half_sel}; end
      OpLhu: begin is_load = 1'b1; aligned = ~a[0]; ld_data = {16'b0, half_sel}; end
      OpLw:  begin is_load = 1'b1; aligned = (a == 2'b00); end
      OpSb:  begin is_store = 1'b1; st_be = 4'b0001 << a; st_data = {4{mem_data_i[7:0]}}; end
      OpSh:  begin
        is_store = 1'b1;
        aligned  = ~a[0];
        st_be    = a[1] ? 4'b1100 : 4'b0011;
        st_data  = {2{mem_data_i[15:0]}};
      end
      OpSw:  begin is_store = 1'b1; aligned = (a == 2'b00); end
      default: ;
    endcase
  end

  // FSM next state, bus drive and WB outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    abort_d     = abort_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdat_d      = wdat_q;
    waddr_o     = waddr_i;
    we_o        = we_i;
    wdata_o     = wdata_i;
    stallreq_o  = 1'b0;
    misalign_o  = 1'b0;
    bus_err_o   = 1'b0;
    bus_req_o   = 1'b0;
    bus_we_o    = 4'b0000;
    bus_addr_o  = addr_q;
    bus_wdata_o = wdat_q;
    unique case (state_q)
      StIdle: begin
        if (is_load || is_store) begin
          we_o = 1'b0;
          if (aligned) begin
            stallreq_o = 1'b1;
            state_d    = StReq;
            cnt_d      = 8'd0;
            abort_d    = 1'b0;
            addr_d     = {mem_addr_i[31:2], 2'b00} & BASE_MASK;
            be_d       = is_store ? st_be : 4'b0000;
            wdat_d     = st_data;
          end else begin
            misalign_o = 1'b1;
          end
        end
      end
      StReq: begin
        bus_req_o  = 1'b1;
        bus_we_o   = be_q;
        stallreq_o = 1'b1;
        we_o       = 1'b0;
        if (bus_ack_i) begin
          rdata_d = bus_rdata_i;
          state_d = StDone;
        end else if (cnt_q == TimeoutLast) begin
          abort_d = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (abort_q) begin
          we_o      = 1'b0;
          bus_err_o = 1'b1;
        end else if (is_load) begin
          wdata_o = ld_data;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      abort_q <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'b0000;
      wdat_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdat_q  <= wdat_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: table of memory ops with a scoreboard queue of expected
// retire results, plus hand-written reset/passthrough/ack-outside-REQ sequences.
module tb_mem_lsu;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_LB   = 8'b1110_0000;
  localparam logic [7:0] OP_LH   = 8'b1110_0001;
  localparam logic [7:0] OP_LW   = 8'b1110_0011;
  localparam logic [7:0] OP_LBU  = 8'b1110_0100;
  localparam logic [7:0] OP_LHU  = 8'b1110_0101;
  localparam logic [7:0] OP_SB   = 8'b1110_1000;
  localparam logic [7:0] OP_SH   = 8'b1110_1001;
  localparam logic [7:0] OP_SW   = 8'b1110_1011;
  localparam int NV = 21;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [31:0] mem_addr, mem_data, wdata_in, wdata_out;
  logic [4:0]  waddr_in, waddr_out;
  logic        we_in, we_out, stallreq, misalign, bus_err, bus_req, bus_ack;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          ack_k;
    logic        we_in;
    logic [31:0] ex_wdata;
    logic [3:0]  x_be;
    logic [31:0] x_bwdata;
    logic [31:0] x_wdata;
    logic        x_we;
    logic        x_mis;
    logic        x_err;
    int          x_stall;
  } vec_t;

  vec_t vecs[NV];
  vec_t sb_q[$];
  int   nvec = 0;
  int   nfail = 0;
  int   cur = -1;

  mem_lsu #(.TIMEOUT(4), .BASE_MASK(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
    .waddr_i(waddr_in), .we_i(we_in), .wdata_i(wdata_in), .waddr_o(waddr_out), .we_o(we_out),
    .wdata_o(wdata_out), .stallreq_o(stallreq), .misalign_o(misalign), .bus_err_o(bus_err),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL [%0d] %s: got 0x%08h, expected 0x%08h", cur, name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    int   stall = 0;
    int   reqn  = 0;
    bit   done  = 0;
    cur = idx;
    @(negedge clk);
    aluop    = v.op;
    mem_addr = v.addr;
    mem_data = v.data;
    waddr_in = 5'(idx + 1);
    we_in    = v.we_in;
    wdata_in = v.ex_wdata;
    bus_ack  = 1'b0;
    sb_q.push_back(v);
    #1;
    if (v.x_mis) begin
      e = sb_q.pop_front();
      chk("misalign_o", 32'(misalign), 32'(e.x_mis));
      chk("stallreq_o", 32'(stallreq), 32'(0));
      chk("we_o", 32'(we_out), 32'(e.x_we));
      chk("bus_err_o", 32'(bus_err), 32'(0));
      @(negedge clk);
      aluop = OP_NOP;
      #1;
      chk("bus_req_o after misalign", 32'(bus_req), 32'(0));
      chk("misalign_o pulse end", 32'(misalign), 32'(0));
      return;
    end
    for (int c = 0; c < 400 && !done; c++) begin
      if (stallreq) begin
        stall++;
        if (bus_req) begin
          if (reqn == 0) begin
            chk("bus_we_o", 32'(bus_we), 32'(v.x_be));
            chk("bus_addr_o", bus_addr, v.addr & 32'hFFFF_FFFC);
            if (v.x_be != 4'b0000) chk("bus_wdata_o", bus_wdata, v.x_bwdata);
          end
          bus_ack   = (reqn == v.ack_k);
          bus_rdata = bus_ack ? v.rdata : 32'h0BAD_F00D;
          reqn++;
        end
      end else if (stall > 0) begin
        e = sb_q.pop_front();
        chk("stall cycles", 32'(stall), 32'(e.x_stall));
        chk("we_o", 32'(we_out), 32'(e.x_we));
        chk("bus_err_o", 32'(bus_err), 32'(e.x_err));
        chk("waddr_o", 32'(waddr_out), 32'(idx + 1));
        chk("bus_req_o in retire", 32'(bus_req), 32'(0));
        if (!e.x_err) chk("wdata_o", wdata_out, e.x_wdata);
        bus_ack = 1'b0;
        done = 1;
      end
      if (!done) step();
    end
    if (!done) begin
      nvec++;
      nfail++;
      $display("FAIL [%0d] retire timeout: got no retire, expected one", idx);
      sb_q.delete();
    end
    @(negedge clk);
    aluop   = OP_NOP;
    bus_ack = 1'b0;
  endtask

  initial begin
    // op, addr, data, rdata, ack_k, we_in, ex_wdata, x_be, x_bwdata, x_wdata, x_we, x_mis, x_err, x_stall
    vecs[0]  = '{OP_LW,  32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b1, 32'hA5A50000,
                 4'b0000, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 4};
    vecs[1]  = '{OP_LB,  32'h103, 32'h0, 32'h80FF0000, 0, 1'b1, 32'hA5A50000,
                 4'b0000, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0, 2};
    vecs[2]  = '{OP_LBU, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b1, 32'hA5A50000,
                 4'b0000, 32'h0, 32'h00000080, 1'b1, 1'b0, 1'b0, 3};
    vecs[3]  = '{OP_LHU, 32'h102, 32'h0, 32'h80FF0000, 0, 1'b1, 32'hA5A50000,
                 4'b0000, 32'h0, 32'h000080FF, 1'b1, 1'b0, 1'b0, 2};
    vecs[4]  = '{OP_LH,  32'h102, 32'h0, 32'h80FF0000, 3, 1'b1, 32'hA5A50000,
                 4'b0000, 32'h0, 32'hFFFF80FF, 1'b1, 1'b0, 1'b0, 5};
    vecs[5]  = '{OP_LH,  32'h100, 32'h0, 32'h12348765, 0, 1'b1, 32'hA5A50000,
                 4'b0000, 32'h0, 32'hFFFF8765, 1'b1, 1'b0, 1'b0, 2};
    vecs[6]  = '{OP_LHU, 32'h100, 32'h0, 32'h12348765, 1, 1'b1, 32'hA5A50000,
                 4'b0000, 32'h0, 32'h00008765, 1'b1, 1'b0, 1'b0, 3};
    vecs[7]  = '{OP_LB,  32'h101, 32'h0, 32'h12348765, 0, 1'b1, 32'hA5A50000,
                 4'b0000, 32'h0, 32'hFFFFFF87, 1'b1, 1'b0, 1'b0, 2};
    vecs[8]  = '{OP_LBU, 32'h100, 32'h0, 32'h12348765, 0, 1'b1, 32'hA5A50000,
                 4'b0000, 32'h0, 32'h00000065, 1'b1, 1'b0, 1'b0, 2};
    vecs[9]  = '{OP_SB,  32'h201, 32'h12345678, 32'h0, 1, 1'b0, 32'h11110000,
                 4'b0010, 32'h78787878, 32'h11110000, 1'b0, 1'b0, 1'b0, 3};
    vecs[10] = '{OP_SH,  32'h202, 32'h12345678, 32'h0, 0, 1'b1, 32'h22220000,
                 4'b1100, 32'h56785678, 32'h22220000, 1'b1, 1'b0, 1'b0, 2};
    vecs[11] = '{OP_SW,  32'h204, 32'hCAFEF00D, 32'h0, 2, 1'b0, 32'h00000000,
                 4'b1111, 32'hCAFEF00D, 32'h00000000, 1'b0, 1'b0, 1'b0, 4};
    vecs[12] = '{OP_SB,  32'h203, 32'h000000AB, 32'h0, 0, 1'b1, 32'h00000033,
                 4'b1000, 32'hABABABAB, 32'h00000033, 1'b1, 1'b0, 1'b0, 2};
    vecs[13] = '{OP_SH,  32'h200, 32'h0000BEEF, 32'h0, 0, 1'b0, 32'h00000044,
                 4'b0011, 32'hBEEFBEEF, 32'h00000044, 1'b0, 1'b0, 1'b0, 2};
    vecs[14] = '{OP_LW,  32'h102, 32'h0, 32'h0, 0, 1'b1, 32'hA5A50000,
                 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 0};
    vecs[15] = '{OP_SH,  32'h201, 32'h0, 32'h0, 0, 1'b1, 32'hA5A50000,
                 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 0};
    vecs[16] = '{OP_LH,  32'h103, 32'h0, 32'h0, 0, 1'b1, 32'hA5A50000,
                 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 0};
    vecs[17] = '{OP_SW,  32'h101, 32'h0, 32'h0, 0, 1'b1, 32'hA5A50000,
                 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 0};
    vecs[18] = '{OP_LW,  32'h300, 32'h0, 32'h0, 1000, 1'b1, 32'hA5A50000,
                 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5};
    vecs[19] = '{OP_LW,  32'h104, 32'h0, 32'h01020304, 3, 1'b1, 32'hA5A50000,
                 4'b0000, 32'h0, 32'h01020304, 1'b1, 1'b0, 1'b0, 5};
    vecs[20] = '{OP_LB,  32'h102, 32'h0, 32'h80FF0000, 0, 1'b1, 32'hA5A50000,
                 4'b0000, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 2};

    rst = 1'b0; aluop = OP_NOP; mem_addr = '0; mem_data = '0; waddr_in = 5'd0;
    we_in = 1'b0; wdata_in = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset bus_req_o", 32'(bus_req), 32'(0));
    chk("reset bus_we_o", 32'(bus_we), 32'(0));
    chk("reset misalign_o", 32'(misalign), 32'(0));
    chk("reset bus_err_o", 32'(bus_err), 32'(0));
    chk("reset stallreq_o", 32'(stallreq), 32'(0));
    @(negedge clk);
    rst = 1'b1;

    // ADDU passthrough: combinational, no stall.
    @(negedge clk);
    aluop = OP_ADDU; wdata_in = 32'd7; waddr_in = 5'd9; we_in = 1'b1;
    #1;
    chk("addu wdata_o", wdata_out, 32'd7);
    chk("addu waddr_o", 32'(waddr_out), 32'd9);
    chk("addu we_o", 32'(we_out), 32'd1);
    chk("addu stallreq_o", 32'(stallreq), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Reset while a request is outstanding.
    cur = 100;
    @(negedge clk);
    aluop = OP_LW; mem_addr = 32'h400; we_in = 1'b1; bus_ack = 1'b0;
    step();
    chk("pre-reset bus_req_o", 32'(bus_req), 32'(1));
    rst = 1'b0; aluop = OP_NOP;
    step();
    chk("reset-in-REQ bus_req_o", 32'(bus_req), 32'(0));
    chk("reset-in-REQ stallreq_o", 32'(stallreq), 32'(0));
    chk("reset-in-REQ bus_err_o", 32'(bus_err), 32'(0));
    rst = 1'b1;
    step();
    chk("post-reset bus_req_o", 32'(bus_req), 32'(0));

    // Ack outside REQ must not start anything.
    cur = 101;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    step();
    chk("stray ack bus_req_o", 32'(bus_req), 32'(0));
    chk("stray ack stallreq_o", 32'(stallreq), 32'(0));
    bus_ack = 1'b0;
    run_vec(vecs[8], 8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
